// File: rtl/div_issue_stage.sv
// Divider issue stage: 2-entry operand FIFO feeding an external combinational divider, plus one result register.
// One cycle from acceptance to out_valid; in_ready depends only on FIFO occupancy, so 3 pairs can be buffered in total.
module div_issue_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       div_a,
  output logic [3:0]       div_b,
  input  logic [3:0]       div_q,
  input  logic [3:0]       div_r,
  input  logic             div_dbz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_q,
  output logic [3:0]       out_r,
  output logic             out_dbz,
  output logic [CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } pair_t;

  pair_t      mem [2];
  pair_t      head;
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;
  logic       fifo_nonempty;

  assign fifo_nonempty = (count != 2'd0);
  assign in_ready      = (count != 2'd2);
  assign push          = in_valid && in_ready;
  assign pop           = fifo_nonempty && (!out_valid || out_ready);
  assign head          = mem[rd_ptr];

  // Empty FIFO presents zero operands so the divider input never shows stale data.
  assign div_a = fifo_nonempty ? head.a : 4'h0;
  assign div_b = fifo_nonempty ? head.b : 4'h0;

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= 4'h0;
      out_r     <= 4'h0;
      out_dbz   <= 1'b0;
      err_cnt   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_dbz   <= div_dbz;
      // Divide-by-zero reports all-ones quotient and the dividend as remainder.
      out_q     <= div_dbz ? 4'hF : div_q;
      out_r     <= div_dbz ? head.a : div_r;
      if (div_dbz && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_issue_stage.sv
// Bench for div_issue_stage: directed literal cases plus randomized traffic against an occupancy/queue model.
module tb_div_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_a = 4'h0;
  logic [3:0] in_b = 4'h0;

  logic       in_ready, out_valid, out_dbz, div_dbz;
  logic [3:0] div_a, div_b, div_q, div_r, out_q, out_r;
  logic [7:0] err_cnt;

  logic       in_ready2, out_valid2, out_dbz2, div_dbz2;
  logic [3:0] div_a2, div_b2, div_q2, div_r2, out_q2, out_r2;
  logic [1:0] err_cnt2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .div_dbz(div_dbz),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_dbz(out_dbz), .err_cnt(err_cnt)
  );

  div_issue_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .div_a(div_a2), .div_b(div_b2),
    .div_q(div_q2), .div_r(div_r2), .div_dbz(div_dbz2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_q(out_q2), .out_r(out_r2),
    .out_dbz(out_dbz2), .err_cnt(err_cnt2)
  );

  // Combinational dividers; on divide-by-zero they return junk the stage must override.
  always_comb begin
    div_dbz = (div_b == 4'h0);
    div_q   = div_dbz ? 4'h5 : div_a / div_b;
    div_r   = div_dbz ? 4'hA : div_a % div_b;
  end
  always_comb begin
    div_dbz2 = (div_b2 == 4'h0);
    div_q2   = div_dbz2 ? 4'h6 : div_a2 / div_b2;
    div_r2   = div_dbz2 ? 4'hB : div_a2 % div_b2;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // {quotient, remainder, dbz} for a packed {a,b} pair.
  function automatic logic [8:0] ref_div(input logic [7:0] p);
    int a, b;
    a = int'(p[7:4]);
    b = int'(p[3:0]);
    if (b == 0) return {4'hF, p[7:4], 1'b1};
    return {4'(a / b), 4'(a % b), 1'b0};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Model: every accepted pair in order, prefix count of divide-by-zero pairs, and number consumed.
  logic [7:0] acc_q[$];
  int         pfx[$];
  int         con_cnt = 0;
  int         last_acc = 0;
  bit         prev_rst = 1'b1;
  int         total, exp_ov, fifo_cnt, n_iss;
  logic [8:0] exp_res;
  logic [7:0] exp_head;

  initial pfx.push_back(0);

  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_q", out_q, 0);
      chk("rst_out_r", out_r, 0);
      chk("rst_out_dbz", out_dbz, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_err_cnt2", err_cnt2, 0);
    end else begin
      total    = acc_q.size() - con_cnt;
      exp_ov   = ((total - last_acc) > 0) ? 1 : 0;
      fifo_cnt = total - exp_ov;
      chk("out_valid", out_valid, exp_ov);
      chk("out_valid2", out_valid2, exp_ov);
      chk("in_ready", in_ready, (fifo_cnt < 2) ? 1 : 0);
      chk("in_ready2", in_ready2, (fifo_cnt < 2) ? 1 : 0);
      if (exp_ov == 1) begin
        exp_res = ref_div(acc_q[con_cnt]);
        chk("out_q", out_q, exp_res[8:5]);
        chk("out_r", out_r, exp_res[4:1]);
        chk("out_dbz", out_dbz, exp_res[0]);
        chk("out_q2", out_q2, exp_res[8:5]);
        chk("out_r2", out_r2, exp_res[4:1]);
      end
      n_iss = con_cnt + exp_ov;
      chk("err_cnt", err_cnt, sat(pfx[n_iss], 255));
      chk("err_cnt2", err_cnt2, sat(pfx[n_iss], 3));
      if (fifo_cnt > 0) begin
        exp_head = acc_q[n_iss];
        chk("div_a", div_a, exp_head[7:4]);
        chk("div_b", div_b, exp_head[3:0]);
      end else begin
        chk("div_a_idle", div_a, 0);
        chk("div_b_idle", div_b, 0);
      end
    end
    if (!rst_n) begin
      acc_q.delete();
      pfx.delete();
      pfx.push_back(0);
      con_cnt  = 0;
      last_acc = 0;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      last_acc = (in_valid && in_ready) ? 1 : 0;
      if (in_valid && in_ready) begin
        acc_q.push_back({in_a, in_b});
        pfx.push_back(pfx[pfx.size()-1] + ((in_b == 4'h0) ? 1 : 0));
      end
      if (out_valid && out_ready) con_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int err2_exp [5] = '{1, 2, 3, 3, 3};
  int vrate, rrate;

  initial begin
    // Reset with live-looking traffic that must be ignored.
    rst_n = 1'b0; in_valid = 1'b1; in_a = 4'd3; in_b = 4'd1; out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();

    // 7/2 -> 3 r1, one cycle after acceptance.
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd2;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("lit_7_2_valid", out_valid, 1);
    chk("lit_7_2_q", out_q, 3);
    chk("lit_7_2_r", out_r, 1);
    chk("lit_7_2_dbz", out_dbz, 0);
    step();

    // 9/0 -> F r9, dbz, first error.
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd0;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("lit_9_0_q", out_q, 15);
    chk("lit_9_0_r", out_r, 9);
    chk("lit_9_0_dbz", out_dbz, 1);
    chk("lit_9_0_err", err_cnt, 1);
    step();

    // Three pairs under backpressure fill the stage, then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd15; in_b = 4'd4;
    step();
    in_a = 4'd6; in_b = 4'd3;
    step();
    in_a = 4'd8; in_b = 4'd8;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_full_in_ready", in_ready, 0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("lit_drain0_q", out_q, 3);
    chk("lit_drain0_r", out_r, 3);
    step();
    @(negedge clk);
    chk("lit_drain1_q", out_q, 2);
    chk("lit_drain1_r", out_r, 0);
    step();
    @(negedge clk);
    chk("lit_drain2_q", out_q, 1);
    chk("lit_drain2_r", out_r, 0);
    step();

    // Saturation of the 2-bit error counter.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      in_valid = 1'b1; in_a = 4'(i + 3); in_b = 4'd0;
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      chk("lit_err2_sat", err_cnt2, err2_exp[i]);
      chk("lit_err8", err_cnt, i + 1);
    end

    // Fill everything, then reset for one cycle: nothing may survive.
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 4'(i + 1); in_b = (i == 0) ? 4'd0 : 4'd1;
      step();
    end
    rst_n = 1'b0; in_a = 4'd12; in_b = 4'd5; out_ready = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("lit_rst_valid", out_valid, 0);
    chk("lit_rst_ready", in_ready, 1);
    chk("lit_rst_err", err_cnt, 0);
    repeat (3) step();
    @(negedge clk);
    chk("lit_rst_no_stale", out_valid, 0);

    // Randomized traffic with varying stall rates and one mid-run reset.
    vrate = 3; rrate = 3;
    for (int i = 0; i < 10000; i++) begin
      if ((i % 1000) == 0) begin
        vrate = $urandom_range(1, 5);
        rrate = $urandom_range(1, 5);
      end
      rst_n     = (i == 5000) ? 1'b0 : 1'b1;
      in_valid  = ($urandom_range(0, 4) < vrate);
      out_ready = ($urandom_range(0, 4) < rrate);
      in_a      = 4'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("drain_all_consumed", con_cnt, acc_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_issue_stage.md
DIV_ISSUE_STAGE -- requirements
Module: div_issue_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of divide-by-zero error counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept an operand pair.
REQ-006 SHALL have port in_a  input  4  dividend.
REQ-007 SHALL have port in_b  input  4  divisor.
REQ-008 SHALL have port div_a  output  4  dividend driven to the combinational 4-bit divider.
REQ-009 SHALL have port div_b  output  4  divisor driven to the combinational 4-bit divider.
REQ-010 SHALL have port div_q  input  4  quotient returned by divider.
REQ-011 SHALL have port div_r  input  4  remainder returned by divider.
REQ-012 SHALL have port div_dbz  input  1  divide-by-zero flag returned by divider.
REQ-013 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port out_q  output  4  registered quotient.
REQ-016 SHALL have port out_r  output  4  registered remainder.
REQ-017 SHALL have port out_dbz  output  1  registered divide-by-zero flag.
REQ-018 SHALL have port err_cnt  output  CNT_W  count of divide-by-zero results captured.

Function
REQ-019 SHALL hold operands in a 2-entry FIFO (count 0..2, 1-bit wrapping read/write pointers).
REQ-020 SHALL drive in_ready = (count < 2), registered-state only, no combinational path from in_valid or out_ready.
REQ-021 SHALL push {in_a,in_b} when in_valid && in_ready.
REQ-022 SHALL drive div_a/div_b from FIFO head; when FIFO empty, drive 4'h0/4'h0.
REQ-023 SHALL pop (issue) when count > 0 && (!out_valid || out_ready).
REQ-024 On issue, SHALL load out_q/out_r/out_dbz from div_q/div_r/div_dbz and set out_valid = 1.
REQ-025 On issue with div_dbz = 1, SHALL force out_q = 4'hF and out_r = head dividend regardless of div_q/div_r.
REQ-026 SHALL clear out_valid when out_valid && out_ready and no issue occurs that cycle.
REQ-027 SHALL hold out_q/out_r/out_dbz stable while out_valid && !out_ready.
REQ-028 Simultaneous push and pop SHALL leave count unchanged and preserve order (FIFO, no reordering).
REQ-029 Latency: pair accepted at edge N, with empty FIFO and result slot free, SHALL be out_valid after edge N+1; throughput one result per cycle while out_ready = 1.
REQ-030 SHALL increment err_cnt by 1 on each issue with div_dbz = 1, saturating at 2^CNT_W-1.
REQ-031 Total buffering SHALL be 3 pairs (2 FIFO + 1 result); in_ready low only when count = 2.
REQ-032 Push when in_ready = 0 SHALL be ignored; no FIFO state change.

Reset
REQ-033 While rst_n = 0 at a rising edge: count = 0, pointers = 0, out_valid = 0, out_q = 4'h0, out_r = 4'h0, out_dbz = 0, err_cnt = 0; in_ready = 1 after that edge.
REQ-034 Reset mid-operation SHALL discard all queued and captured results; no result issued before reset appears after it.
REQ-035 in_valid and out_ready SHALL be ignored in reset cycles.

Verification
REQ-036 Push 7/2, out_ready = 1 -> next cycle out_valid = 1, out_q = 3, out_r = 1, out_dbz = 0.
REQ-037 Push 9/0 -> out_q = 4'hF, out_r = 9, out_dbz = 1, err_cnt = 1.
REQ-038 out_ready = 0, push 15/4, 6/3, 8/8 back-to-back -> in_ready = 0 after third push; release out_ready -> results 3r3, 2r0, 1r0 in order, one per cycle.
REQ-039 CNT_W = 2, issue five x/0 divisions -> err_cnt sequence 1, 2, 3, 3, 3.
REQ-040 Fill FIFO and result slot, assert rst_n = 0 one cycle -> out_valid = 0, in_ready = 1, err_cnt = 0; no stale result after release.
REQ-041 Random pairs with random in_valid/out_ready stalls over 10k cycles -> output stream equals in-order scoreboard of a/b, a%b (dbz: F, a).
